// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 raster timing constants and coordinate type
// Imported by vga_timing_gen and by the pixel-colour stage so both agree on
// the raster geometry. No ports.
package vga_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync pulse occupies the columns/lines straight after the front porch.
    localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - system clock divider producing a one-clk pixel enable
// Ports: clk, rst (async, active-high), pix_en (high one clk in every PIX_DIV).
module vga_pix_div #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int DW = $clog2(PIX_DIV);
    localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          pix_en_q, pix_en_d;

    // pix_en is registered from the next count so it is high exactly while the
    // counter holds PIX_DIV-1, without a combinational output path.
    always_comb begin
        cnt_d    = cnt_q + DW'(1);
        pix_en_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pix_en_q <= pix_en_d;
        end
    end

    assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/bright decodes and player position latch
// Ports: clk, rst (async, active-high); pos_x_in/pos_y_in/pos_valid position
// request, pos_ack commit pulse; pix_en pixel strobe; hCount/vCount raster
// position; bright, hSync, vSync (syncs active-low); frame_start vblank-entry
// pulse; player_x/player_y committed position.
// Macro VGA_POS_LATCH_EN: defined -> position commits only at vblank entry;
// undefined -> position is a plain registered copy of the request.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV = 4,
    parameter int H_VIS   = VGA_H_VIS,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_VIS   = VGA_V_VIS,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pos_x_in,
    input  logic [9:0] pos_y_in,
    input  logic       pos_valid,
    output logic       pos_ack,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       frame_start,
    output logic [9:0] player_x,
    output logic [9:0] player_y
);

    localparam coord_t H_LAST   = coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VIS);
    localparam coord_t V_VIS_C  = coord_t'(V_VIS);
    localparam coord_t HS_FIRST = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_VIS + V_FP + V_SYNC - 1);

    logic   pix_en_w;
    coord_t h_next, v_next;
    coord_t hcount_q, hcount_d, vcount_q, vcount_d;
    logic   bright_q, bright_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic   frame_start_q, frame_start_d, pos_ack_q, pos_ack_d;
    coord_t player_x_q, player_x_d, player_y_q, player_y_d;
`ifdef VGA_POS_LATCH_EN
    coord_t pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic   dirty_q, dirty_d;
`endif

    vga_pix_div #(.PIX_DIV(PIX_DIV)) u_pix_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en_w)
    );

    always_comb begin
        h_next = (hcount_q == H_LAST) ? '0 : hcount_q + coord_t'(1);
        v_next = vcount_q;
        if (hcount_q == H_LAST) begin
            v_next = (vcount_q == V_LAST) ? '0 : vcount_q + coord_t'(1);
        end

        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        bright_d      = bright_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;

        // Decodes are taken from the next counter values so they land on the
        // same edge as the counters and always describe what hCount/vCount show.
        if (pix_en_w) begin
            hcount_d      = h_next;
            vcount_d      = v_next;
            bright_d      = (h_next < H_VIS_C) && (v_next < V_VIS_C);
            hsync_d       = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
            vsync_d       = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
            frame_start_d = (h_next == '0) && (v_next == V_VIS_C);
        end

        player_x_d = player_x_q;
        player_y_d = player_y_q;
        pos_ack_d  = 1'b0;
`ifdef VGA_POS_LATCH_EN
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        dirty_d  = dirty_q;
        // Commit reads the pending value before this clk's capture, so a request
        // arriving on the commit clk stays pending for the next frame.
        if (frame_start_d && dirty_q) begin
            player_x_d = pend_x_q;
            player_y_d = pend_y_q;
            pos_ack_d  = 1'b1;
            dirty_d    = 1'b0;
        end
        if (pos_valid) begin
            pend_x_d = pos_x_in;
            pend_y_d = pos_y_in;
            dirty_d  = 1'b1;
        end
`else
        if (pos_valid) begin
            player_x_d = pos_x_in;
            player_y_d = pos_y_in;
            pos_ack_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            bright_q      <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            pos_ack_q     <= 1'b0;
            player_x_q    <= '0;
            player_y_q    <= '0;
`ifdef VGA_POS_LATCH_EN
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            dirty_q       <= 1'b0;
`endif
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            bright_q      <= bright_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            pos_ack_q     <= pos_ack_d;
            player_x_q    <= player_x_d;
            player_y_q    <= player_y_d;
`ifdef VGA_POS_LATCH_EN
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            dirty_q       <= dirty_d;
`endif
        end
    end

    assign pix_en      = pix_en_w;
    assign hCount      = hcount_q;
    assign vCount      = vcount_q;
    assign bright      = bright_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign frame_start = frame_start_q;
    assign pos_ack     = pos_ack_q;
    assign player_x    = player_x_q;
    assign player_y    = player_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

    localparam int PD = 4;
    localparam int HV = 16, HF = 2, HS = 4, HB = 2;
    localparam int VV = 12, VF = 2, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int NPIX = HT * VT;
    localparam int FRAME = NPIX * PD;
    localparam int COMMIT_LIN = VV * HT;
`ifdef VGA_POS_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pos_x_in = '0, pos_y_in = '0;
    logic       pos_valid = 1'b0;
    logic       pos_ack, pix_en, bright, hSync, vSync, frame_start;
    logic [9:0] hCount, vCount, player_x, player_y;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

    pos_t       sb[$];
    int         vectors = 0, miscompares = 0;
    int         n = 0, abs_n = 0;
    logic [9:0] cur_x = '0, cur_y = '0;
    int         st_bright, st_hlow, st_vlow, st_fs;
    int         fs_prev = 0, fs_last = 0;

    vga_timing_gen #(
        .PIX_DIV(PD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pos_x_in    (pos_x_in),
        .pos_y_in    (pos_y_in),
        .pos_valid   (pos_valid),
        .pos_ack     (pos_ack),
        .pix_en      (pix_en),
        .hCount      (hCount),
        .vCount      (vCount),
        .bright      (bright),
        .hSync       (hSync),
        .vSync       (vSync),
        .frame_start (frame_start),
        .player_x    (player_x),
        .player_y    (player_y)
    );

    always #5 clk = ~clk;

    // Raster position (linear pixel index) after k clk edges since reset release.
    function automatic int lin(input int k);
        return (NPIX - 1 + k / PD) % NPIX;
    endfunction

    function automatic bit is_commit(input int k);
        return (k > 0) && (k % PD == 0) && (lin(k) == COMMIT_LIN);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        int   l, h, v;
        logic fs_exp, ack_exp;
        pos_t p;
        l = lin(n);
        h = l % HT;
        v = l / HT;
        fs_exp = is_commit(n);
        chk("pix_en", 32'(pix_en), 32'(n % PD == PD - 1));
        chk("hCount", 32'(hCount), h);
        chk("vCount", 32'(vCount), v);
        chk("bright", 32'(bright), 32'(h < HV && v < VV));
        chk("hSync", 32'(hSync), 32'(!(h >= HV + HF && h < HV + HF + HS)));
        chk("vSync", 32'(vSync), 32'(!(v >= VV + VF && v < VV + VF + VS)));
        chk("frame_start", 32'(frame_start), 32'(fs_exp));
        if (LATCH) ack_exp = fs_exp && (sb.size() > 0);
        else       ack_exp = (sb.size() > 0);
        if (ack_exp) begin
            p = sb.pop_front();
            cur_x = p.x;
            cur_y = p.y;
        end
        chk("pos_ack", 32'(pos_ack), 32'(ack_exp));
        chk("player_x", 32'(player_x), 32'(cur_x));
        chk("player_y", 32'(player_y), 32'(cur_y));
        if (n > 0 && n % PD == 0) begin
            if (bright === 1'b1) st_bright++;
            if (hSync === 1'b0)  st_hlow++;
            if (vSync === 1'b0)  st_vlow++;
        end
        if (frame_start === 1'b1) begin
            st_fs++;
            fs_prev = fs_last;
            fs_last = abs_n;
        end
    endtask

    // Drive one clk of stimulus; push marks a request expected to reach player_x/y.
    task automatic cyc(input logic v, input logic [9:0] x, input logic [9:0] y, input bit push);
        pos_valid = v;
        pos_x_in  = x;
        pos_y_in  = y;
        if (push) sb.push_back('{x: x, y: y});
        @(negedge clk);
        n++;
        abs_n++;
        pos_valid = 1'b0;
        check_all();
    endtask

    task automatic run_to_commit();
        for (int i = 0; i < FRAME + PD; i++) begin
            cyc(1'b0, '0, '0, 1'b0);
            if (is_commit(n)) break;
        end
    endtask

    task automatic run_to_line(input int line);
        for (int i = 0; i < FRAME + PD; i++) begin
            cyc(1'b0, '0, '0, 1'b0);
            if (lin(n) == line * HT) break;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_hCount"}, 32'(hCount), HT - 1);
        chk({tag, "_vCount"}, 32'(vCount), VT - 1);
        chk({tag, "_bright"}, 32'(bright), 0);
        chk({tag, "_hSync"}, 32'(hSync), 1);
        chk({tag, "_vSync"}, 32'(vSync), 1);
        chk({tag, "_pix_en"}, 32'(pix_en), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_pos_ack"}, 32'(pos_ack), 0);
        chk({tag, "_player_x"}, 32'(player_x), 0);
        chk({tag, "_player_y"}, 32'(player_y), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        n = 0;

        // First frame from release: pix_en on clk 4, counters (0,0) on clk 5,
        // then the whole frame against the raster model plus aggregate counts.
        st_bright = 0; st_hlow = 0; st_vlow = 0; st_fs = 0;
        repeat (FRAME) cyc(1'b0, '0, '0, 1'b0);
        chk("bright_pixels", st_bright, HV * VV);
        chk("hsync_low_pixels", st_hlow, HS * VT);
        chk("vsync_low_pixels", st_vlow, VS * HT);
        chk("frame_starts", st_fs, 1);
        run_to_commit();
        chk("frame_spacing", fs_last - fs_prev, FRAME);

        // Single mid-frame request
        run_to_line(6);
        cyc(1'b1, 10'd100, 10'd200, 1'b1);
        run_to_commit();
        chk("single_x", 32'(player_x), 100);
        chk("single_y", 32'(player_y), 200);

        // Two requests in one frame, then a frame with none
        run_to_line(3);
        cyc(1'b1, 10'd10, 10'd10, !LATCH);
        repeat (7) cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b1, 10'd20, 10'd30, 1'b1);
        run_to_commit();
        chk("last_wins_x", 32'(player_x), 20);
        chk("last_wins_y", 32'(player_y), 30);
        run_to_commit();
        chk("idle_frame_ack", 32'(pos_ack), 0);
        chk("idle_frame_x", 32'(player_x), 20);

        // Request landing on the exact commit clk while another is pending
        run_to_line(5);
        cyc(1'b1, 10'd1, 10'd2, 1'b1);
        for (int i = 0; i < FRAME && !is_commit(n + 1); i++) cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b1, 10'd55, 10'd66, 1'b1);
        run_to_commit();
        chk("collide_next_x", 32'(player_x), 55);
        chk("collide_next_y", 32'(player_y), 66);

        // Asynchronous reset mid-frame with a request pending
        run_to_line(6);
        cyc(1'b1, 10'd7, 10'd9, 1'b1);
        repeat (5) cyc(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        #1;
        sb.delete();
        cur_x = '0;
        cur_y = '0;
        check_reset_state("midframe_reset");
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        run_to_commit();
        chk("discarded_ack", 32'(pos_ack), 0);
        chk("discarded_x", 32'(player_x), 0);
        repeat (8) cyc(1'b0, '0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the 640x480@60 Hz VGA path. It divides the system clock to a pixel enable and runs the horizontal and vertical counters. It produces registered `hCount`, `vCount`, `bright`, `hSync` and `vSync` for the pixel-colour stage. It also holds the player position that the pixel-colour stage draws, updating it only at the start of vertical blank so the sprite never tears mid-frame.

## Interface
Parameters:
- `PIX_DIV`, 4: system clocks per pixel; power of two, ≥2.
- `H_VIS`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal timing in pixels; total 800.
- `V_VIS`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical timing in lines; total 525.

Ports:
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `pos_x_in` in 10: requested player x.
- `pos_y_in` in 10: requested player y.
- `pos_valid` in 1: request strobe; the position is captured on any clk where this is high.
- `pos_ack` out 1: one-clk pulse when the pending position is committed.
- `pix_en` out 1: one-clk pulse per pixel.
- `hCount` out 10: pixel column, 0..799.
- `vCount` out 10: line, 0..524.
- `bright` out 1: high in the visible region.
- `hSync` out 1: horizontal sync, active-low.
- `vSync` out 1: vertical sync, active-low.
- `frame_start` out 1: one-clk pulse at vblank entry.
- `player_x` out 10: committed player x.
- `player_y` out 10: committed player y.

## Operation
- **Divider:**
  - A log2(`PIX_DIV`)-bit counter increments every clk and wraps.
  - `pix_en` is high when the counter equals `PIX_DIV`-1.
- **Counters** advance only on `pix_en`:
  - `hCount` wraps 799→0.
  - `vCount` increments when `hCount` wraps, and itself wraps 524→0.
- **Decodes:** `bright`, `hSync` and `vSync` are registered on the same `pix_en` edge as the counters, so they always describe the current (`hCount`, `vCount`).
  - `bright` = `hCount` < 640 && `vCount` < 480.
  - `hSync` low for `hCount` 656..751.
  - `vSync` low for `vCount` 490..491.
- **Position pending register:**
  - Captured on every clk with `pos_valid`; last write wins.
  - A dirty flag is set on capture.
- **Commit:**
  - Occurs on the `pix_en` edge where the counters become (0, 480).
  - On that edge `frame_start` pulses.
  - If dirty: `player_x`/`player_y` are loaded from pending, `pos_ack` pulses in the same clk, and dirty clears.
  - If not dirty: no `pos_ack`, and the outputs hold.
- **Simultaneous capture and commit:** a `pos_valid` arriving on the commit clk is not part of this commit. The old pending value commits, the new value is captured, and dirty stays set for the next frame.
- **Coordinates:** 10-bit unsigned with no range clamping. Clipping is the consumer's job.

## Timing
- **Reset values:**
  - Divider 0.
  - `hCount`=799, `vCount`=524 (last pixel of the frame).
  - `bright`=0, `hSync`=1, `vSync`=1.
  - `pix_en`=0, `frame_start`=0, `pos_ack`=0.
  - `player_x`=0, `player_y`=0, pending=0, dirty=0.
- **After reset release:**
  - The first `pix_en` is on the `PIX_DIV`-th clk.
  - The counters move to (0,0) one clk later, with `bright`=1.
- **Decode latency:** counters and decodes change together, one clk after `pix_en`.
- **Frame period:** 800×525×`PIX_DIV` clks (1,680,000 at `PIX_DIV`=4).
- **`frame_start` spacing:** exactly one frame period apart.
- **`pos_ack`:** coincident with `frame_start`, never otherwise.
- **Reset mid-frame:** all state returns to reset values immediately. A pending position is discarded.

## Configuration
- `VGA_POS_LATCH_EN` defined:
  - Frame-synchronous commit as described above.
- `VGA_POS_LATCH_EN` undefined:
  - `player_x`/`player_y` are registered copies of `pos_x_in`/`pos_y_in`, loaded on every `pos_valid` clk with 1-clk latency.
  - `pos_ack` pulses in that same clk as the load.
  - The pending register and dirty flag are removed.
  - `frame_start` is unchanged.

## Structure
- **Shared package `vga_pkg`:**
  - The timing constants: visible, porch and sync widths, totals 800/525.
  - Derived sync start/end columns and lines.
  - The 10-bit coordinate type.
  - The pixel-colour stage imports the same constants.
- **One sub-module, `vga_pix_div`:** the clock divider producing `pix_en`. The counters, decodes and position latch stay in the top.

## Test plan
- Reset, then run 4 clks: `pix_en` is high on clk 4 only; on clk 5 the counters read (0,0), `bright`=1, `hSync`=1, `vSync`=1.
- Run one full frame, 1,680,000 clks: `hSync` low for 96 pixels starting at `hCount`=656; `vSync` low on lines 490–491 only; `bright` high for exactly 307,200 pixels.
- Pulse `pos_valid` with (100,200) mid-frame at line 100: `player_x`/`player_y` stay 0 until line 480/col 0, then read (100,200) with `pos_ack` and `frame_start` in the same clk.
- Write (10,10) then (20,30) within one frame: only (20,30) commits, and one `pos_ack`. In the next frame with no write: `frame_start` pulses, no `pos_ack`, outputs hold.
- Assert `pos_valid` (55,66) on the exact commit clk while (1,2) is pending: (1,2) commits now; (55,66) commits at the following `frame_start`.
- Assert `rst` at line 300: counters immediately read 799/524, `bright`=0, syncs 1; the pending position is discarded and does not commit at the next `frame_start`.
